// File: rtl/bus_if_pkg.sv
// Shared constants and state encoding for the bus_if memory front end.
// Active-low strobe levels and read/write encodings live here too.
package bus_if_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int SPM_ADDR_W  = 12;
  localparam int IDX_W       = 3;
  localparam int SPM_IDX     = 1;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    STALL
  } bus_state_t;

endpackage

// File: rtl/bus_if.sv
// Per-stage memory front end: scratchpad accesses pass straight through,
// everything else runs a req/grant/ready bus transaction while busy stalls.
module bus_if #(
  parameter int WORD_ADDR_W = bus_if_pkg::WORD_ADDR_W,
  parameter int WORD_DATA_W = bus_if_pkg::WORD_DATA_W,
  parameter int SPM_ADDR_W  = bus_if_pkg::SPM_ADDR_W,
  parameter int IDX_W       = bus_if_pkg::IDX_W,
  parameter int SPM_IDX     = bus_if_pkg::SPM_IDX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  input  logic [WORD_DATA_W-1:0] spm_rd_data,
  output logic [SPM_ADDR_W-1:0]  spm_addr,
  output logic                   spm_as_,
  output logic                   spm_rw,
  output logic [WORD_DATA_W-1:0] spm_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  input  logic                   bus_grnt_,
  output logic                   bus_req_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data
);
  import bus_if_pkg::*;

  bus_state_t             state, state_n;
  logic                   req_n, as_n, rw_n;
  logic [WORD_ADDR_W-1:0] addr_n;
  logic [WORD_DATA_W-1:0] wd_n;
  logic [WORD_DATA_W-1:0] rd_buf, rd_buf_n;
  logic [IDX_W-1:0]       idx;
  logic                   is_spm;
  logic                   issue;

  assign idx    = addr[WORD_ADDR_W-1 -: IDX_W];
  assign is_spm = (idx == IDX_W'(SPM_IDX));
  assign issue  = !flush && (as_ == ENABLE_) && !is_spm;

  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      state       <= state_n;
      bus_req_    <= req_n;
      bus_as_     <= as_n;
      bus_rw      <= rw_n;
      bus_addr    <= addr_n;
      bus_wr_data <= wd_n;
      rd_buf      <= rd_buf_n;
    end
  end

  always_comb begin
    state_n  = state;
    req_n    = bus_req_;
    as_n     = bus_as_;
    rw_n     = bus_rw;
    addr_n   = bus_addr;
    wd_n     = bus_wr_data;
    rd_buf_n = rd_buf;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_n = REQ;
          req_n   = ENABLE_;
          addr_n  = addr;
          rw_n    = rw;
          wd_n    = wr_data;
        end
      end
      REQ: begin
        if (bus_grnt_ == ENABLE_) begin
          state_n = ACCESS;
          as_n    = ENABLE_;
        end
      end
      ACCESS: begin
        as_n = DISABLE_;
        if (bus_rdy_ == ENABLE_) begin
          req_n   = DISABLE_;
          addr_n  = '0;
          wd_n    = '0;
          rw_n    = READ;
          if (bus_rw == READ) rd_buf_n = bus_rd_data;
          state_n = stall ? STALL : IDLE;
        end
      end
      STALL: begin
        if (!stall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs seen by the stage in the current cycle
  always_comb begin
    busy    = 1'b0;
    rd_data = '0;
    spm_as_ = DISABLE_;
    unique case (state)
      IDLE: begin
        if (is_spm) begin
          rd_data = spm_rd_data;
          if (!flush && as_ == ENABLE_) spm_as_ = ENABLE_;
        end
        if (issue) busy = 1'b1;
      end
      REQ: busy = 1'b1;
      ACCESS: begin
        if (bus_rdy_ == ENABLE_) rd_data = bus_rd_data;
        else busy = 1'b1;
      end
      STALL: rd_data = rd_buf;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bus_if.sv
// Randomized bench for bus_if: acts as stage, bus slave and memory.
// Expectations come from transaction-level timing rules and a memory map.
module tb_bus_if;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy;
  logic [29:0] addr;
  logic        as_, rw;
  logic [31:0] wr_data, rd_data, spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data, bus_rd_data;
  logic        bus_rdy_, bus_grnt_, bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] last_rd = '0;

  bus_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .busy(busy), .addr(addr), .as_(as_), .rw(rw),
    .wr_data(wr_data), .rd_data(rd_data),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr),
    .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
    .bus_req_(bus_req_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [29:0] bus_addr_gen();
    logic [2:0] idx;
    idx = 3'($urandom_range(0, 6));
    if (idx >= 3'd1) idx = idx + 3'd1;
    return {idx, 23'd0, 4'($urandom_range(0, 15))};
  endfunction

  task automatic idle_check();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rd", rd_data, 32'd0);
    check("idle_req", 32'(bus_req_), 32'd1);
    check("idle_as", 32'(bus_as_), 32'd1);
    check("idle_addr", 32'(bus_addr), 32'd0);
    check("idle_rw", 32'(bus_rw), 32'd1);
    check("idle_wd", bus_wr_data, 32'd0);
  endtask

  task automatic spm_xfer(input logic [29:0] a, input logic r,
                          input logic [31:0] d);
    logic [31:0] sd;
    @(posedge clk); #1;
    sd = $urandom;
    addr = a; as_ = 1'b0; rw = r; wr_data = d;
    spm_rd_data = sd; flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("spm_as", 32'(spm_as_), 32'd0);
    check("spm_addr", 32'(spm_addr), 32'(a[11:0]));
    check("spm_rw", 32'(spm_rw), 32'(r));
    check("spm_wd", spm_wr_data, d);
    check("spm_rd", rd_data, sd);
    check("spm_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    as_ = 1'b1;
    @(negedge clk);
    check("spm_noreq", 32'(bus_req_), 32'd1);
  endtask

  task automatic flush_idle(input logic [29:0] a);
    @(posedge clk); #1;
    addr = a; as_ = 1'b0; rw = 1'b1; flush = 1'b1; stall = 1'b0;
    @(negedge clk);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_spm_as", 32'(spm_as_), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_noreq", 32'(bus_req_), 32'd1);
    @(posedge clk); #1;
    as_ = 1'b1; flush = 1'b0;
  endtask

  task automatic bus_xfer(input logic [29:0] a, input logic r,
                          input logic [31:0] d, input int g,
                          input int rl, input int s);
    int gc, rc, bc, ac;
    bit granted, acc, done;
    logic [31:0] exp;
    gc = 0; rc = 0; bc = 0; ac = 0;
    granted = 0; acc = 0; done = 0; exp = '0;
    @(posedge clk); #1;
    as_ = 1'b0; addr = a; rw = r; wr_data = d;
    flush = 1'b0; stall = (s > 0);
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        flush = 1'($urandom_range(0, 1));
      end
      bus_rdy_ = 1'b1;
      bus_rd_data = $urandom;
      if (bus_as_ == 1'b0) begin
        ac++;
        if (!acc) begin
          acc = 1;
          check("bus_addr", 32'(bus_addr), 32'(a));
          check("bus_rw", 32'(bus_rw), 32'(r));
        end
      end
      if (acc) begin
        if (!r) check("bus_wd", bus_wr_data, d);
        if (rc == rl) begin
          bus_rdy_ = 1'b0;
          if (r) begin
            exp = mem_rd(a);
            bus_rd_data = exp;
          end
        end else rc++;
      end else if (!granted && bus_req_ == 1'b0) begin
        if (gc == g) begin
          bus_grnt_ = 1'b0;
          granted = 1;
        end else gc++;
      end
      @(negedge clk);
      if (bus_rdy_ == 1'b0) begin
        check("rdy_busy", 32'(busy), 32'd0);
        if (r) begin
          check("rdy_rd", rd_data, exp);
          last_rd = exp;
        end else mem[a] = d;
        done = 1;
      end else if (busy) bc++;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("busy_cycles", 32'(bc), 32'(g + rl + 2));
    check("as_pulses", 32'(ac), 32'd1);
    @(posedge clk); #1;
    as_ = 1'b1; flush = 1'b0;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
    if (s > 0) begin
      for (int i = 0; i <= s; i++) begin
        stall = (i < s);
        @(negedge clk);
        check("stl_busy", 32'(busy), 32'd0);
        check("stl_rd", rd_data, last_rd);
        @(posedge clk); #1;
      end
    end
    stall = 1'b0;
    idle_check();
  endtask

  task automatic reset_in_access();
    @(posedge clk); #1;
    as_ = 1'b0; addr = 30'h100; rw = 1'b1;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; flush = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ra_as", 32'(bus_as_), 32'd0);
    reset = 1'b1; as_ = 1'b1; bus_grnt_ = 1'b1;
    @(negedge clk);
    check("ra_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ra_req", 32'(bus_req_), 32'd1);
    check("ra_bas", 32'(bus_as_), 32'd1);
    check("ra_addr", 32'(bus_addr), 32'd0);
    check("ra_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd = '0;
    idle_check();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    addr = '0; as_ = 1'b1; rw = 1'b1; wr_data = '0;
    spm_rd_data = '0; bus_rd_data = '0;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req", 32'(bus_req_), 32'd1);
    check("rst_as", 32'(bus_as_), 32'd1);
    check("rst_rw", 32'(bus_rw), 32'd1);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_wd", bus_wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    spm_xfer(30'h0800_0010, 1'b1, 32'h0);
    mem[30'h4] = 32'hDEAD_BEEF;
    bus_xfer(30'h4, 1'b1, 32'h0, 2, 3, 0);
    bus_xfer(30'h8, 1'b0, 32'h1234_5678, 1, 2, 2);
    bus_xfer(30'h8, 1'b1, 32'h0, 0, 0, 4);
    flush_idle(30'h40);
    flush_idle(30'h0800_0020);
    reset_in_access();

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind == 0)
        spm_xfer({3'd1, 15'd0, 12'($urandom)},
                 1'($urandom), $urandom);
      else if (kind == 1)
        flush_idle(bus_addr_gen());
      else
        bus_xfer(bus_addr_gen(), 1'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
